// File: rtl/naive_bus_copy_master.sv
// rtl/naive_bus_copy_master.sv - word-granular COPY/FILL DMA master on the naive_bus
//
// Purpose:
//   COPY mode reads i_len words starting at i_src_addr and writes them starting at
//   i_dst_addr, one read then one write per word. FILL mode writes i_pattern to
//   i_len words starting at i_dst_addr and never reads. i_abort stops the transfer
//   at the next safe point. Addresses are word aligned and wrap modulo 2^32.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   i_start, i_fill     start strobe (honoured only when idle), mode select (1 = FILL)
//   i_src_addr          COPY source byte address, bits [1:0] ignored
//   i_dst_addr          destination byte address, bits [1:0] ignored
//   i_len, i_pattern    word count, FILL data
//   i_abort             level-sensitive stop request
//   o_busy, o_done      not-idle flag, one-cycle end-of-transfer pulse
//   o_aborted, o_words  transfer ended by abort, words written so far
//   o_rd_*/i_rd_*       naive_bus read channel (req/gnt/addr, data one cycle after gnt)
//   o_wr_*/i_wr_*       naive_bus write channel (req/gnt/addr/be/data)
module naive_bus_copy_master #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_fill,
  input  logic [31:0]      i_src_addr,
  input  logic [31:0]      i_dst_addr,
  input  logic [LEN_W-1:0] i_len,
  input  logic [31:0]      i_pattern,
  input  logic             i_abort,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_aborted,
  output logic [LEN_W-1:0] o_words,
  output logic             o_rd_req,
  input  logic             i_rd_gnt,
  output logic [31:0]      o_rd_addr,
  input  logic [31:0]      i_rd_data,
  output logic             o_wr_req,
  input  logic             i_wr_gnt,
  output logic [31:0]      o_wr_addr,
  output logic [3:0]       o_wr_be,
  output logic [31:0]      o_wr_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RDATA,
    S_WR,
    S_DONE
  } state_t;

  state_t           state_q;
  logic             fill_q;
  logic [29:0]      src_q, dst_q;      // word addresses; byte bits are always 00
  logic [29:0]      src_d, dst_d;
  logic [LEN_W-1:0] rem_q, words_q;
  logic [31:0]      data_q;            // pattern in FILL, captured read word in COPY
  logic             busy_q, done_q, aborted_q;
  logic             rd_req_q, wr_req_q;
  logic [3:0]       be_q;

  // Word increment wraps naturally at 30 bits, i.e. byte address modulo 2^32.
  assign src_d = src_q + 30'd1;
  assign dst_d = dst_q + 30'd1;

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{i_src_addr[1:0], i_dst_addr[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      fill_q    <= 1'b0;
      src_q     <= '0;
      dst_q     <= '0;
      rem_q     <= '0;
      words_q   <= '0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      rd_req_q  <= 1'b0;
      wr_req_q  <= 1'b0;
      be_q      <= 4'h0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (i_start) begin
            fill_q    <= i_fill;
            src_q     <= i_src_addr[31:2];
            dst_q     <= i_dst_addr[31:2];
            rem_q     <= i_len;
            data_q    <= i_pattern;
            words_q   <= '0;
            aborted_q <= 1'b0;
            be_q      <= 4'hF;
            busy_q    <= 1'b1;
            if (i_len == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else if (i_fill) begin
              state_q  <= S_WR;
              wr_req_q <= 1'b1;
            end else begin
              state_q  <= S_RD;
              rd_req_q <= 1'b1;
            end
          end
        end

        // A read granted on the abort edge has nothing left to complete on
        // our side; the returning word is simply not captured.
        S_RD: begin
          if (i_rd_gnt || i_abort) begin
            rd_req_q <= 1'b0;
            if (i_abort) begin
              state_q   <= S_DONE;
              done_q    <= 1'b1;
              aborted_q <= 1'b1;
            end else begin
              state_q <= S_RDATA;
            end
          end
        end

        S_RDATA: begin
          if (i_abort) begin
            state_q   <= S_DONE;
            done_q    <= 1'b1;
            aborted_q <= 1'b1;
          end else begin
            data_q   <= i_rd_data;
            wr_req_q <= 1'b1;
            state_q  <= S_WR;
          end
        end

        S_WR: begin
          if (i_wr_gnt) begin
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_q - LEN_W'(1);
            words_q <= words_q + LEN_W'(1);
            if (i_abort || rem_q == LEN_W'(1)) begin
              wr_req_q  <= 1'b0;
              state_q   <= S_DONE;
              done_q    <= 1'b1;
              aborted_q <= i_abort;
            end else if (!fill_q) begin
              wr_req_q <= 1'b0;
              rd_req_q <= 1'b1;
              state_q  <= S_RD;
            end
            // FILL keeps wr_req high for back-to-back writes.
          end else if (i_abort) begin
            wr_req_q  <= 1'b0;
            state_q   <= S_DONE;
            done_q    <= 1'b1;
            aborted_q <= 1'b1;
          end
        end

        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_aborted = aborted_q;
  assign o_words   = words_q;
  assign o_rd_req  = rd_req_q;
  assign o_rd_addr = {src_q, 2'b00};
  assign o_wr_req  = wr_req_q;
  assign o_wr_addr = {dst_q, 2'b00};
  assign o_wr_be   = be_q;
  assign o_wr_data = data_q;

endmodule

// File: tb/tb_naive_bus_copy_master.sv
// tb/tb_naive_bus_copy_master.sv - self-checking bench for naive_bus_copy_master
module tb_naive_bus_copy_master;
  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_start, i_fill, i_abort;
  logic [31:0]      i_src_addr, i_dst_addr, i_pattern;
  logic [LEN_W-1:0] i_len;
  logic             o_busy, o_done, o_aborted;
  logic [LEN_W-1:0] o_words;
  logic             o_rd_req, i_rd_gnt, o_wr_req, i_wr_gnt;
  logic [31:0]      o_rd_addr, i_rd_data, o_wr_addr, o_wr_data;
  logic [3:0]       o_wr_be;

  always #5 clk = ~clk;

  naive_bus_copy_master #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_fill(i_fill),
    .i_src_addr(i_src_addr), .i_dst_addr(i_dst_addr), .i_len(i_len),
    .i_pattern(i_pattern), .i_abort(i_abort),
    .o_busy(o_busy), .o_done(o_done), .o_aborted(o_aborted), .o_words(o_words),
    .o_rd_req(o_rd_req), .i_rd_gnt(i_rd_gnt), .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data),
    .o_wr_req(o_wr_req), .i_wr_gnt(i_wr_gnt), .o_wr_addr(o_wr_addr), .o_wr_be(o_wr_be),
    .o_wr_data(o_wr_data)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Slave memory, transfer logs and protocol monitors.
  logic [31:0] mem [logic [31:0]];
  logic [31:0] wa[$], wd[$], ra[$], snap[$];
  bit          kind[$];              // 0 = read transfer, 1 = write transfer
  int          viol_both, viol_stable, viol_fmt, done_cnt, busy_cnt;
  int          gnt_mode = 0;         // 0 tied, 1 random waits, 2 block writes after two
  logic        rd_en = 1'b1, wr_en = 1'b1;
  logic        pend = 1'b0;
  logic [31:0] paddr;
  logic        prev_rd_wait = 1'b0, prev_wr_wait = 1'b0;
  logic [31:0] prev_ra, prev_wa, prev_wdat;

  assign i_rd_gnt = o_rd_req & rd_en;
  assign i_wr_gnt = o_wr_req & wr_en;

  always @(negedge clk) begin
    if (rst) begin
      pend = 1'b0; prev_rd_wait = 1'b0; prev_wr_wait = 1'b0;
    end else begin
      // Read data appears only in the cycle after the grant; garbage otherwise.
      if (pend) begin
        i_rd_data = mem.exists(paddr) ? mem[paddr] : 32'h0;
        pend = 1'b0;
      end else begin
        i_rd_data = $urandom;
      end
      if (o_rd_req && o_wr_req) viol_both++;
      if (prev_rd_wait && o_rd_req && o_rd_addr !== prev_ra) viol_stable++;
      if (prev_wr_wait && o_wr_req && (o_wr_addr !== prev_wa || o_wr_data !== prev_wdat)) viol_stable++;
      if (o_wr_req && (o_wr_be !== 4'hF || o_wr_addr[1:0] !== 2'b00)) viol_fmt++;
      if (o_rd_req && o_rd_addr[1:0] !== 2'b00) viol_fmt++;
      if (o_rd_req && i_rd_gnt) begin
        ra.push_back(o_rd_addr); kind.push_back(1'b0);
        pend = 1'b1; paddr = o_rd_addr;
      end
      if (o_wr_req && i_wr_gnt) begin
        mem[o_wr_addr] = o_wr_data;
        wa.push_back(o_wr_addr); wd.push_back(o_wr_data); kind.push_back(1'b1);
      end
      prev_rd_wait = o_rd_req && !i_rd_gnt; prev_ra = o_rd_addr;
      prev_wr_wait = o_wr_req && !i_wr_gnt; prev_wa = o_wr_addr; prev_wdat = o_wr_data;
      if (o_done) done_cnt++;
      if (o_busy) busy_cnt++;
    end
  end

  always @(posedge clk) begin
    #1;
    case (gnt_mode)
      1:       begin rd_en = ($urandom % 3) != 0; wr_en = ($urandom % 3) != 0; end
      2:       begin rd_en = 1'b1; wr_en = (wa.size() < 2); end
      default: begin rd_en = 1'b1; wr_en = 1'b1; end
    endcase
  end

  task automatic clear_logs();
    wa.delete(); wd.delete(); ra.delete(); kind.delete();
    viol_both = 0; viol_stable = 0; viol_fmt = 0; done_cnt = 0; busy_cnt = 0;
  endtask

  task automatic take_snap(input logic [31:0] src, input int n);
    logic [31:0] a;
    snap.delete();
    for (int i = 0; i < n; i++) begin
      a = src + 32'(4 * i);
      snap.push_back(mem.exists(a) ? mem[a] : 32'h0);
    end
  endtask

  task automatic start_xfer(input bit fill, input logic [31:0] src, input logic [31:0] dst,
                            input logic [31:0] pat, input int len);
    @(negedge clk);
    clear_logs();
    i_start = 1'b1; i_fill = fill; i_src_addr = src; i_dst_addr = dst;
    i_pattern = pat; i_len = LEN_W'(len);
    @(posedge clk); #1;
    // Scramble the inputs after acceptance: everything must have been latched.
    i_start = 1'b0; i_fill = 1'($urandom); i_src_addr = $urandom; i_dst_addr = $urandom;
    i_pattern = $urandom; i_len = LEN_W'($urandom);
  endtask

  // lat = number of edges after the accepting edge until o_done is seen.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!o_done && lat < 3000) begin
      @(posedge clk); #1; lat++;
    end
    check("done_seen", 64'(lat < 3000), 64'd1);
    @(posedge clk); #1;
  endtask

  // Reference: word i goes to dst+4i with pattern or the pre-transfer source word.
  task automatic verify(input string t, input bit fill, input logic [31:0] src,
                        input logic [31:0] dst, input logic [31:0] pat, input int n);
    int bad_a = 0, bad_d = 0, bad_r = 0, bad_k = 0;
    check({t, ".nwr"}, 64'(wa.size()), 64'(n));
    check({t, ".nrd"}, 64'(ra.size()), fill ? 64'd0 : 64'(n));
    for (int i = 0; i < wa.size() && i < n; i++) begin
      if (wa[i] !== dst + 32'(4 * i)) bad_a++;
      if (wd[i] !== (fill ? pat : snap[i])) bad_d++;
    end
    for (int i = 0; i < ra.size() && i < n; i++)
      if (ra[i] !== src + 32'(4 * i)) bad_r++;
    for (int i = 0; i < kind.size(); i++)
      if (kind[i] != (fill ? 1'b1 : 1'(i % 2))) bad_k++;
    check({t, ".wr_addr"}, 64'(bad_a), 64'd0);
    check({t, ".wr_data"}, 64'(bad_d), 64'd0);
    check({t, ".rd_addr"}, 64'(bad_r), 64'd0);
    check({t, ".order"}, 64'(bad_k), 64'd0);
    check({t, ".both_req"}, 64'(viol_both), 64'd0);
    check({t, ".stable"}, 64'(viol_stable), 64'd0);
    check({t, ".be_align"}, 64'(viol_fmt), 64'd0);
    check({t, ".done_cnt"}, 64'(done_cnt), 64'd1);
    check({t, ".words"}, 64'(o_words), 64'(n));
    check({t, ".aborted"}, 64'(o_aborted), 64'd0);
    check({t, ".busy_end"}, 64'(o_busy), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [31:0] src, dst, pat;
    rst = 1'b1; i_start = 1'b0; i_fill = 1'b0; i_abort = 1'b0;
    i_src_addr = '0; i_dst_addr = '0; i_len = '0; i_pattern = '0; i_rd_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.busy", 64'(o_busy), 64'd0);
    check("rst.done", 64'(o_done), 64'd0);
    check("rst.aborted", 64'(o_aborted), 64'd0);
    check("rst.words", 64'(o_words), 64'd0);
    check("rst.reqs", 64'({o_rd_req, o_wr_req}), 64'd0);
    check("rst.bus", 64'({o_rd_addr, o_wr_addr} | 64'({o_wr_data, o_wr_be})), 64'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // COPY 4 words, grants tied to requests.
    for (int i = 0; i < 4; i++) mem[32'h100 + 32'(4 * i)] = $urandom;
    take_snap(32'h100, 4);
    start_xfer(1'b0, 32'h100, 32'h200, 32'h0, 4);
    wait_done(lat);
    check("copy4.latency", 64'(lat), 64'd12);
    verify("copy4", 1'b0, 32'h100, 32'h200, 32'h0, 4);

    // FILL 8 words back to back.
    start_xfer(1'b1, 32'h0, 32'h0, 32'hDEADBEEF, 8);
    wait_done(lat);
    check("fill8.latency", 64'(lat), 64'd8);
    verify("fill8", 1'b1, 32'h0, 32'h0, 32'hDEADBEEF, 8);

    // COPY 16 words with random wait states, a few different regions.
    gnt_mode = 1;
    for (int k = 0; k < 3; k++) begin
      src = 32'h0001_0000 + (32'($urandom_range(0, 1023)) << 2);
      dst = 32'h0010_0000 + (32'($urandom_range(0, 1023)) << 2);
      for (int i = 0; i < 16; i++) mem[src + 32'(4 * i)] = $urandom;
      take_snap(src, 16);
      start_xfer(1'b0, src | 32'($urandom_range(0, 3)), dst | 32'($urandom_range(0, 3)), 32'h0, 16);
      wait_done(lat);
      verify("copy16w", 1'b0, src, dst, 32'h0, 16);
    end
    // FILL with random waits.
    pat = $urandom;
    start_xfer(1'b1, 32'h0, 32'h2000, pat, 10);
    wait_done(lat);
    verify("fill10w", 1'b1, 32'h0, 32'h2000, pat, 10);
    gnt_mode = 0;

    // Zero length: no bus traffic, immediate single done.
    start_xfer(1'b0, 32'h100, 32'h300, 32'h0, 0);
    wait_done(lat);
    check("len0.latency", 64'(lat), 64'd0);
    check("len0.busy_cycles", 64'(busy_cnt), 64'd1);
    check("len0.traffic", 64'(wa.size() + ra.size()), 64'd0);
    check("len0.done_cnt", 64'(done_cnt), 64'd1);
    check("len0.words", 64'(o_words), 64'd0);

    // Abort during the 3rd write with wr_gnt held low; a start while busy is ignored.
    gnt_mode = 2;
    for (int i = 0; i < 8; i++) mem[32'h400 + 32'(4 * i)] = $urandom;
    take_snap(32'h400, 8);
    start_xfer(1'b0, 32'h400, 32'h500, 32'h0, 8);
    for (int k = 0; k < 50 && wa.size() < 1; k++) @(negedge clk);
    i_start = 1'b1; i_fill = 1'b1; i_dst_addr = 32'h9000; i_len = LEN_W'(1);
    @(negedge clk);
    i_start = 1'b0;
    for (int k = 0; k < 50 && !(wa.size() == 2 && o_wr_req); k++) @(negedge clk);
    repeat (2) @(negedge clk);
    i_abort = 1'b1;
    lat = 0;
    while (!o_done && lat < 50) begin @(posedge clk); #1; lat++; end
    check("abort.done_seen", 64'(lat < 50), 64'd1);
    @(negedge clk);
    i_abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort.words", 64'(o_words), 64'd2);
    check("abort.aborted", 64'(o_aborted), 64'd1);
    check("abort.done_cnt", 64'(done_cnt), 64'd1);
    check("abort.nwr", 64'(wa.size()), 64'd2);
    check("abort.nrd", 64'(ra.size()), 64'd3);
    check("abort.wr0", 64'(wa.size() > 0 ? wa[0] : 32'hx), 64'h500);
    check("abort.wr1", 64'(wa.size() > 1 ? wa[1] : 32'hx), 64'h504);
    check("abort.data1", 64'(wd.size() > 1 ? wd[1] : 32'hx), 64'(snap[1]));
    check("abort.busy", 64'(o_busy), 64'd0);
    check("abort.reqs", 64'({o_rd_req, o_wr_req}), 64'd0);
    gnt_mode = 0;

    // FILL across the top of the address space; new start clears o_aborted.
    start_xfer(1'b1, 32'h0, 32'hFFFF_FFF8, 32'hA5A5_0001, 3);
    wait_done(lat);
    verify("wrap", 1'b1, 32'h0, 32'hFFFF_FFF8, 32'hA5A5_0001, 3);
    check("wrap.third", 64'(wa.size() > 2 ? wa[2] : 32'hx), 64'h0);

    // Reset in the middle of a long FILL.
    start_xfer(1'b1, 32'h0, 32'h3000, 32'h1234_5678, 100);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rstmid.reqs", 64'({o_rd_req, o_wr_req}), 64'd0);
    check("rstmid.busy", 64'(o_busy), 64'd0);
    check("rstmid.words", 64'(o_words), 64'd0);
    done_cnt = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rstmid.no_done", 64'(done_cnt), 64'd0);
    check("rstmid.idle", 64'({o_busy, o_wr_req}), 64'd0);
    check("rstmid.partial", 64'(wa.size() < 100), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
